input_debounce: RTL and testbench
=================================

// Module: input_debounce
// PURPOSE
//   Conditions a raw asynchronous input (button/switch/emulated pin) for the edge-detect stage.
//   Synchronises the input into i_clk, then accepts a level change only after it has held for
//   STABLE_COUNT consecutive i_ce ticks. o_data is a clean, glitch-free level for the
//   rising-edge detector that sits directly downstream.
// PARAMETERS
//   SYNC_STAGES   2     synchroniser flops on i_data (>=2)
//   CNT_WIDTH     16    width of the stability counter
//   STABLE_COUNT  1000  i_ce ticks the new level must hold (1 .. 2**CNT_WIDTH-1)
//   RESET_LEVEL   0     value of the sync chain and o_data during and after reset
// PORTS
//   i_clk      in   1  system clock; all state is on the rising edge
//   i_reset_n  in   1  asynchronous, active-low reset
//   i_ce       in   1  clock enable / sample tick; advances only the stability counter
//   i_data     in   1  raw asynchronous input
//   o_data     out  1  debounced level (registered)
//   o_busy     out  1  1 while a candidate change is being qualified (registered)
//   o_glitch   out  1  one-clock pulse when a candidate change is rejected (registered)
// BEHAVIOUR
//   Reset: sync chain=RESET_LEVEL, o_data=RESET_LEVEL, state=ST_STABLE, count=0, o_busy=0, o_glitch=0.
//     Assertion is asynchronous and takes effect mid-qualification: the count is lost.
//     Release is synchronous to i_clk.
//   Sync chain: shifts every i_clk and is NOT gated by i_ce. s = last stage.
//   ST_STABLE:
//     s != o_data -> ST_COUNTING, count=0, o_busy=1. Else hold.
//   ST_COUNTING, evaluated every clock with priority top-down:
//     - s == o_data: go to ST_STABLE, count=0, o_busy=0, o_glitch=1 for one clock.
//       The abort occurs on any clock, whether or not i_ce is high.
//     - i_ce && count == STABLE_COUNT-1: o_data <= s, go to ST_STABLE, count=0, o_busy=0.
//     - i_ce: count <= count+1.
//     - otherwise hold.
//   Latency: a clean step on i_data appears on o_data after SYNC_STAGES clocks plus the
//     STABLE_COUNT-th i_ce tick seen while in ST_COUNTING.
//     Example: ce=1 always gives SYNC_STAGES+1+STABLE_COUNT clocks from the i_data edge.
//   STABLE_COUNT=1: commit on the first i_ce after entering ST_COUNTING.
//   Counter: unsigned CNT_WIDTH; never wraps, because it is cleared at commit/abort.
//   Elaboration error if STABLE_COUNT is 0 or >= 2**CNT_WIDTH, or SYNC_STAGES < 2.
//   o_data changes at most once per qualification and never toggles twice within one clock.
//   i_ce held low: counting freezes, but aborts still happen.
// STRUCTURE
//   Shared package debounce_pkg: state encoding ST_STABLE=1'b0, ST_COUNTING=1'b1, and the
//     parameter-check macro.
//   One sub-module, sync_chain #(SYNC_STAGES, RESET_LEVEL): i_clk, i_reset_n, i_d, o_q.
//     Built from plain flops with no enable.
//   Top level holds the FSM, the counter and the output registers.
// TESTING   (STABLE_COUNT=4, SYNC_STAGES=2, RESET_LEVEL=0 unless noted)
//   1. Reset mid-count, ce=1:
//      i_data 0->1, assert i_reset_n=0 at clock 4
//      -> o_data=0, o_busy=0 immediately; after release with i_data=1, o_data=1 9 clocks later.
//   2. Clean step, ce=1:
//      i_data 0->1 at t0
//      -> o_busy=1 at t0+3; o_data=1 at t0+7; o_glitch never asserts.
//   3. Glitch, ce=1:
//      i_data high for 3 clocks then low
//      -> o_busy pulses, o_glitch=1 for exactly one clock, o_data stays 0.
//   4. Sparse ce (one tick every 10 clocks):
//      i_data 0->1
//      -> o_data rises on the 4th ce tick after o_busy rises, not before.
//   5. Falling edge, and a reversion while i_ce=0:
//      from o_data=1, drop i_data for 2 ticks, restore between ticks
//      -> immediate abort, o_glitch pulse, o_data=1.
//   6. STABLE_COUNT=1, RESET_LEVEL=1:
//      reset -> o_data=1; i_data=0 held -> o_data=0 exactly 4 clocks after the edge with ce=1.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer: FSM state encoding and the
// elaboration-time parameter check used by the top level.
`ifndef DEBOUNCE_PKG_SV
`define DEBOUNCE_PKG_SV

// Expands to a generate block that stops elaboration on an illegal configuration.
`define DEBOUNCE_CHECK_PARAMS(SYNC, CW, SC) \
  if (((SYNC) < 2) || ((SC) < 1) || (64'(SC) >= (64'd1 << (CW)))) begin : g_bad_params \
    $error("input_debounce: illegal SYNC_STAGES/CNT_WIDTH/STABLE_COUNT"); \
  end

package debounce_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

endpackage

`endif

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for one asynchronous bit; plain flops, no enable.
// Latency SYNC_STAGES clocks; resets every stage to RESET_LEVEL.
module sync_chain #(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], i_d};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Debounces a raw asynchronous input: synchronise, then commit a level change only
// after it has held for STABLE_COUNT i_ce ticks; any reversion aborts with o_glitch.
`include "debounce_pkg.sv"

module input_debounce
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_WIDTH    = 16,
  parameter int STABLE_COUNT = 1000,
  parameter bit RESET_LEVEL  = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_ce,
  input  logic i_data,
  output logic o_data,
  output logic o_busy,
  output logic o_glitch
);

  `DEBOUNCE_CHECK_PARAMS(SYNC_STAGES, CNT_WIDTH, STABLE_COUNT)

  localparam logic [CNT_WIDTH-1:0] COUNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  logic sync_s;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync_chain (
    .i_clk     (i_clk),
    .i_reset_n (rst_n),
    .i_d       (i_data),
    .o_q       (sync_s)
  );

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 glitch_q, glitch_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    data_d   = data_q;
    busy_d   = busy_q;
    glitch_d = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (sync_s != data_q) begin
          state_d = ST_COUNTING;
          count_d = '0;
          busy_d  = 1'b1;
        end
      end
      ST_COUNTING: begin
        // A reversion aborts regardless of i_ce.
        if (sync_s == data_q) begin
          state_d  = ST_STABLE;
          count_d  = '0;
          busy_d   = 1'b0;
          glitch_d = 1'b1;
        end else if (i_ce && (count_q == COUNT_LAST)) begin
          data_d  = sync_s;
          state_d = ST_STABLE;
          count_d = '0;
          busy_d  = 1'b0;
        end else if (i_ce) begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_STABLE;
        count_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_STABLE;
      count_q  <= '0;
      data_q   <= RESET_LEVEL;
      busy_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      glitch_q <= glitch_d;
    end
  end

  assign o_data   = data_q;
  assign o_busy   = busy_q;
  assign o_glitch = glitch_q;

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench: main instance STABLE_COUNT=4/RESET_LEVEL=0, second instance
// STABLE_COUNT=1/RESET_LEVEL=1; outputs sampled 1ns after each rising edge.
module tb_input_debounce;

  logic clk;
  logic rst_n, ce, din, dout, busy, glitch;
  logic rst_n2, ce2, din2, dout2, busy2, glitch2;
  int   tests_run;
  int   tests_failed;

  input_debounce #(
    .SYNC_STAGES (2), .CNT_WIDTH (16), .STABLE_COUNT (4), .RESET_LEVEL (1'b0)
  ) dut (
    .i_clk (clk), .i_reset_n (rst_n), .i_ce (ce), .i_data (din),
    .o_data (dout), .o_busy (busy), .o_glitch (glitch)
  );

  input_debounce #(
    .SYNC_STAGES (2), .CNT_WIDTH (16), .STABLE_COUNT (1), .RESET_LEVEL (1'b1)
  ) dut2 (
    .i_clk (clk), .i_reset_n (rst_n2), .i_ce (ce2), .i_data (din2),
    .o_data (dout2), .o_busy (busy2), .o_glitch (glitch2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if (dout !== 1'b0 || busy !== 1'b0 || glitch !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: data/busy/glitch=%b%b%b want 000", dout, busy, glitch);
    end
    tests_run++;
    if (dout2 !== 1'b1 || busy2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_level1: data/busy=%b%b want 10", dout2, busy2);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    rst_n2 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (dout !== 1'b0 || busy !== 1'b0 || dout2 !== 1'b1 || busy2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_release_idle: d/b=%b%b d2/b2=%b%b want 00 10", dout, busy, dout2, busy2);
    end
  endtask

  task automatic test_clean_step();
    din = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      tests_run++;
      if (busy !== ((e >= 3 && e < 7) ? 1'b1 : 1'b0)) begin
        tests_failed++;
        $display("FAIL step_busy clk%0d: got %b", e, busy);
      end
      tests_run++;
      if (dout !== ((e >= 7) ? 1'b1 : 1'b0)) begin
        tests_failed++;
        $display("FAIL step_data clk%0d: got %b", e, dout);
      end
      tests_run++;
      if (glitch !== 1'b0) begin
        tests_failed++;
        $display("FAIL step_glitch clk%0d: got %b want 0", e, glitch);
      end
    end
  endtask

  // Drop the input, let two ce ticks count, restore it with ce low.
  task automatic test_revert_ce_low();
    ce  = 1'b0;
    din = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      ce = (e == 4 || e == 5) ? 1'b1 : 1'b0;
      if (e == 6) din = 1'b1;
      tick();
      tests_run++;
      if (busy !== ((e >= 3 && e <= 7) ? 1'b1 : 1'b0) ||
          glitch !== ((e == 8) ? 1'b1 : 1'b0) || dout !== 1'b1) begin
        tests_failed++;
        $display("FAIL revert clk%0d: data/busy/glitch=%b%b%b", e, dout, busy, glitch);
      end
    end
    ce = 1'b1;
  endtask

  task automatic test_clean_fall();
    din = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 6 || e == 7) begin
        tests_run++;
        if (dout !== ((e == 7) ? 1'b0 : 1'b1)) begin
          tests_failed++;
          $display("FAIL fall_data clk%0d: got %b", e, dout);
        end
      end
    end
  endtask

  task automatic test_glitch();
    din = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      if (e == 4) din = 1'b0;
      tick();
      tests_run++;
      if (busy !== ((e >= 3 && e <= 5) ? 1'b1 : 1'b0) ||
          glitch !== ((e == 6) ? 1'b1 : 1'b0) || dout !== 1'b0) begin
        tests_failed++;
        $display("FAIL glitch clk%0d: data/busy/glitch=%b%b%b", e, dout, busy, glitch);
      end
    end
  endtask

  task automatic test_sparse_ce();
    int   ticks;
    logic early;
    logic busy_before;
    ticks = 0;
    early = 1'b0;
    din   = 1'b1;
    for (int cyc = 1; cyc <= 200 && ticks < 4; cyc++) begin
      ce          = (cyc % 10 == 0) ? 1'b1 : 1'b0;
      busy_before = busy;
      tick();
      if (busy_before && ce) ticks++;
      if (ticks < 4 && dout === 1'b1) early = 1'b1;
    end
    ce = 1'b0;
    tests_run++;
    if (ticks !== 4) begin
      tests_failed++;
      $display("FAIL sparse_timeout: saw %0d qualifying ticks want 4", ticks);
    end
    tests_run++;
    if (early !== 1'b0) begin
      tests_failed++;
      $display("FAIL sparse_early: o_data rose before 4th tick");
    end
    tests_run++;
    if (dout !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL sparse_commit: data/busy=%b%b want 10", dout, busy);
    end
  endtask

  task automatic test_reset_mid_count();
    ce    = 1'b1;
    din   = 1'b0;
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    din = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midcount_busy: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (dout !== 1'b0 || busy !== 1'b0 || glitch !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: data/busy/glitch=%b%b%b want 000", dout, busy, glitch);
    end
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e >= 4) begin
        tests_run++;
        if (dout !== ((e == 9) ? 1'b1 : 1'b0) ||
            busy !== ((e >= 5 && e <= 8) ? 1'b1 : 1'b0)) begin
          tests_failed++;
          $display("FAIL release_clk%0d: data/busy=%b%b", e, dout, busy);
        end
      end
    end
  endtask

  task automatic test_stable1();
    din2 = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      tests_run++;
      if (dout2 !== ((e >= 4) ? 1'b0 : 1'b1) ||
          busy2 !== ((e == 3) ? 1'b1 : 1'b0) || glitch2 !== 1'b0) begin
        tests_failed++;
        $display("FAIL stable1 clk%0d: data/busy/glitch=%b%b%b", e, dout2, busy2, glitch2);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n  = 1'b0;
    ce     = 1'b1;
    din    = 1'b0;
    rst_n2 = 1'b0;
    ce2    = 1'b1;
    din2   = 1'b1;
    test_reset();
    test_clean_step();
    test_revert_ce_low();
    test_clean_fall();
    test_glitch();
    test_sparse_ce();
    test_reset_mid_count();
    test_stable1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
